// File: rtl/video_vga_scan.sv
// video_vga_scan: TV-to-VGA line doubler scan engine.
// TV pixels arriving on c3 go into one 512x8 line bank. The other bank is
// replayed twice per TV line on f0, which runs at twice the c3 rate. The
// banks swap roles on every valid TV line start.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   c3, f0             TV / VGA pixel strobes (one clk wide)
//   tv_line_start      TV line start, only honoured together with c3
//   vplex_in[7:0]      TV palette index for the current c3 pixel
//   vgaplex[7:0]       VGA palette index (forced to 0 while blanked)
//   vga_blank, vga_hs  VGA blank and active-high horizontal sync
//   vga_line           0 = first replay of the TV line, 1 = later replays
//   vga_plex_sel       hires nibble select: 0 on f0-derived cycles, else 1
// All outputs lag the read counter by two clocks (RAM read, output register).
module video_vga_scan #(
  parameter int LINE_LEN  = 448,
  parameter int HS_START  = 0,
  parameter int HS_END    = 32,
  parameter int ACT_START = 96,
  parameter int ACT_END   = 416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c3,
  input  logic       f0,
  input  logic       tv_line_start,
  input  logic [7:0] vplex_in,
  output logic [7:0] vgaplex,
  output logic       vga_blank,
  output logic       vga_hs,
  output logic       vga_line,
  output logic       vga_plex_sel
);
  localparam logic [8:0] RD_LAST = 9'(LINE_LEN - 1);
  localparam logic [9:0] HS_S    = 10'(HS_START);
  localparam logic [9:0] HS_W    = 10'(HS_END - HS_START);
  localparam logic [9:0] ACT_S   = 10'(ACT_START);
  localparam logic [9:0] ACT_W   = 10'(ACT_END - ACT_START);

  // Bank b occupies addresses {b, 9'addr}.
  logic [7:0] mem [0:1023];

  logic       wbank;
  logic [8:0] wcnt;
  logic [8:0] rcnt;
  logic       synced;
  logic       line_r;

  logic       resync;
  logic       wsel;
  logic [8:0] waddr;
  logic [9:0] rcnt_x;
  logic       blank_c;
  logic       hs_c;

  // Stage-1 registers, aligned with the RAM read data.
  logic [7:0] rd_data;
  logic       p1_blank;
  logic       p1_hs;
  logic       p1_line;
  logic       p1_sel;

  assign resync = c3 & tv_line_start;
  // On a line start the pixel of that cycle is pixel 0 of the new bank.
  assign wsel   = resync ? ~wbank : wbank;
  assign waddr  = resync ? 9'd0 : wcnt;
  assign rcnt_x = {1'b0, rcnt};

  // Window tests as (x - start) < width in modular arithmetic; this avoids
  // constant-true compares when a window starts at 0.
  assign blank_c = ~synced | ~((rcnt_x - ACT_S) < ACT_W);
  assign hs_c    = synced & ((rcnt_x - HS_S) < HS_W);

  // Line banks; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && c3) mem[{wsel, waddr}] <= vplex_in;
    rd_data <= mem[{~wbank, rcnt}];
  end

  // Write/read counters and line-replay state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank  <= 1'b0;
      wcnt   <= 9'd0;
      rcnt   <= 9'd0;
      synced <= 1'b0;
      line_r <= 1'b0;
    end else if (resync) begin
      wbank  <= ~wbank;
      wcnt   <= 9'd1;
      rcnt   <= 9'd0;
      line_r <= 1'b0;
      synced <= 1'b1;
    end else begin
      // Saturate: an overlong TV line keeps rewriting the last cell.
      if (c3 && wcnt != 9'd511) wcnt <= wcnt + 9'd1;
      if (f0) begin
        if (rcnt == RD_LAST) begin
          rcnt   <= 9'd0;
          line_r <= 1'b1;  // stays 1 if the TV line start is late
        end else begin
          rcnt   <= rcnt + 9'd1;
        end
      end
    end
  end

  // Two-stage output pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_blank     <= 1'b1;
      p1_hs        <= 1'b0;
      p1_line      <= 1'b0;
      p1_sel       <= 1'b0;
      vgaplex      <= 8'h00;
      vga_blank    <= 1'b1;
      vga_hs       <= 1'b0;
      vga_line     <= 1'b0;
      vga_plex_sel <= 1'b0;
    end else begin
      p1_blank     <= blank_c;
      p1_hs        <= hs_c;
      p1_line      <= line_r;
      p1_sel       <= ~f0;
      vgaplex      <= p1_blank ? 8'h00 : rd_data;
      vga_blank    <= p1_blank;
      vga_hs       <= p1_hs;
      vga_line     <= p1_line;
      vga_plex_sel <= p1_sel;
    end
  end
endmodule

// File: tb/tb_video_vga_scan.sv
// Scoreboard bench for video_vga_scan. The driver steps one clock at a time,
// runs a line-level model of the banks and counters, and queues the output
// expected two clocks later. The monitor checks the queue head each cycle.
module tb_video_vga_scan;
  localparam int LINE_LEN  = 448;
  localparam int HS_START  = 0;
  localparam int HS_END    = 32;
  localparam int ACT_START = 96;
  localparam int ACT_END   = 416;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c3 = 1'b0;
  logic       f0 = 1'b0;
  logic       tv_line_start = 1'b0;
  logic [7:0] vplex_in = 8'h00;
  logic [7:0] vgaplex;
  logic       vga_blank, vga_hs, vga_line, vga_plex_sel;

  video_vga_scan #(
    .LINE_LEN(LINE_LEN), .HS_START(HS_START), .HS_END(HS_END),
    .ACT_START(ACT_START), .ACT_END(ACT_END)
  ) dut (
    .clk(clk), .rst(rst), .c3(c3), .f0(f0), .tv_line_start(tv_line_start),
    .vplex_in(vplex_in), .vgaplex(vgaplex), .vga_blank(vga_blank),
    .vga_hs(vga_hs), .vga_line(vga_line), .vga_plex_sel(vga_plex_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         known;
    logic [7:0] plex;
    logic       blank, hs, line, sel;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur = -1;

  // Model: banks hold -1 for never-written cells.
  int   m_bank [2][512];
  bit   m_wb;
  int   m_wc, m_rc;
  bit   m_synced, m_line;
  bit   addr_mode;

  function automatic exp_t rst_exp(input int c);
    exp_t e;
    e.cyc = c; e.known = 1'b1; e.plex = 8'h00;
    e.blank = 1'b1; e.hs = 1'b0; e.line = 1'b0; e.sel = 1'b0;
    return e;
  endfunction

  task automatic step(input bit r, input bit tl);
    bit         c3v, f0v;
    logic [7:0] pix;
    exp_t       e;
    int         d;
    @(posedge clk); #1;
    cur++;
    c3v = (cur % 4 == 0);
    f0v = (cur % 2 == 0);
    if (addr_mode) pix = (c3v && tl) ? 8'h00 : 8'(m_wc);
    else           pix = 8'($urandom);
    rst = r; c3 = c3v; f0 = f0v; tv_line_start = tl; vplex_in = pix;

    if (r) begin
      e = rst_exp(cur + 2);
      // The output register clears on the very next edge as well.
      if (q.size() > 0 && q[$].cyc == cur + 1) q[$] = rst_exp(cur + 1);
    end else begin
      e.cyc   = cur + 2;
      e.blank = !m_synced || m_rc < ACT_START || m_rc >= ACT_END;
      e.hs    = m_synced && m_rc >= HS_START && m_rc < HS_END;
      e.line  = m_line;
      e.sel   = !f0v;
      if (e.blank) begin
        e.known = 1'b1; e.plex = 8'h00;
      end else begin
        d = m_bank[!m_wb][m_rc];
        e.known = (d >= 0);
        e.plex  = 8'(d);
      end
    end
    q.push_back(e);

    if (r) begin
      m_wb = 0; m_wc = 0; m_rc = 0; m_synced = 0; m_line = 0;
    end else if (c3v && tl) begin
      m_wb = !m_wb;
      m_bank[m_wb][0] = int'(pix);
      m_wc = 1; m_rc = 0; m_line = 0; m_synced = 1;
    end else begin
      if (c3v) begin
        m_bank[m_wb][m_wc] = int'(pix);
        if (m_wc < 511) m_wc++;
      end
      if (f0v) begin
        if (m_rc == LINE_LEN - 1) begin m_rc = 0; m_line = 1; end
        else m_rc++;
      end
    end
  endtask

  // One TV line of n c3 strobes, starting with a valid tv_line_start.
  task automatic tv_line(input int n);
    int k;
    bit c;
    k = 0;
    while (k < n) begin
      c = ((cur + 1) % 4 == 0);
      step(1'b0, c && k == 0);
      if (c) k++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cur) begin
      e = q.pop_front();
      checks++;
      if ({vga_blank, vga_hs, vga_line, vga_plex_sel} !== {e.blank, e.hs, e.line, e.sel}) begin
        errors++;
        $display("FAIL ctl cyc=%0d blank/hs/line/sel got %b%b%b%b want %b%b%b%b", cur,
                 vga_blank, vga_hs, vga_line, vga_plex_sel, e.blank, e.hs, e.line, e.sel);
      end
      if (e.known) begin
        checks++;
        if (vgaplex !== e.plex) begin
          errors++;
          $display("FAIL vgaplex cyc=%0d got %h want %h", cur, vgaplex, e.plex);
        end
      end
    end
  end

  initial begin
    bit hit;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) m_bank[b][a] = -1;
    m_wb = 0; m_wc = 0; m_rc = 0; m_synced = 0; m_line = 0;
    addr_mode = 0;

    repeat (3) step(1'b1, 1'b0);
    // Strobes running, no line start: must stay blanked.
    repeat (2000) step(1'b0, 1'b0);

    // Address-pattern lines, then random-data lines.
    addr_mode = 1;
    repeat (3) tv_line(LINE_LEN);
    addr_mode = 0;
    repeat (2) tv_line(LINE_LEN);

    // Stray line starts without c3 are ignored.
    repeat (400) step(1'b0, ($urandom_range(0, 7) == 0) && ((cur + 1) % 4 != 0));

    // Late line start: write saturates, extra replays keep vga_line=1.
    addr_mode = 1;
    tv_line(1000);
    tv_line(LINE_LEN);
    addr_mode = 0;
    tv_line(LINE_LEN);

    // Short lines leave stale tail data.
    tv_line(300);
    tv_line(300);
    tv_line(LINE_LEN);

    // Reset during active video at rcnt=200.
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      if (m_synced && m_rc == 200) hit = 1;
      else step(1'b0, 1'b0);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_point reached=%0d want 1", hit);
    end
    repeat (2) step(1'b1, 1'b0);
    repeat (600) step(1'b0, 1'b0);
    tv_line(LINE_LEN);
    tv_line(LINE_LEN);
    repeat (8) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_vga_scan.md
VIDEO_VGA_SCAN -- requirements
Module: video_vga_scan

Interface
REQ-001 SHALL have parameter LINE_LEN, default 448, meaning TV line length in c3 strobes and VGA line length in f0 strobes.
REQ-002 SHALL have parameter HS_START, default 0, meaning first read count with vga_hs asserted.
REQ-003 SHALL have parameter HS_END, default 32, meaning first read count with vga_hs deasserted.
REQ-004 SHALL have parameter ACT_START, default 96, meaning first unblanked read count.
REQ-005 SHALL have parameter ACT_END, default 416, meaning first blanked read count after active.
REQ-006 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 c3  in  1  TV pixel strobe, one clk wide, every 4th clk.
REQ-009 f0  in  1  VGA pixel strobe, one clk wide, every 2nd clk.
REQ-010 tv_line_start  in  1  TV line start, valid only when c3=1.
REQ-011 vplex_in  in  8  TV palette index for the current c3 pixel.
REQ-012 vgaplex  out  8  VGA palette index for the DAC stage.
REQ-013 vga_blank  out  1  VGA blank.
REQ-014 vga_hs  out  1  VGA horizontal sync, active-high.
REQ-015 vga_line  out  1  0 = first replay of TV line, 1 = second replay.
REQ-016 vga_plex_sel  out  1  hires nibble select: 0 in f0 cycle, 1 in the following cycle.

Function
REQ-017 SHALL contain two line banks of 512 x 8; wbank selects the write bank; rbank = ~wbank.
REQ-018 Write: on c3=1, vplex_in written to bank wbank at wcnt, then wcnt+1; wcnt saturates at 511 (no wrap, no overwrite of address 0).
REQ-019 On c3=1 and tv_line_start=1: wbank toggles, wcnt<=0 with that cycle's pixel written to address 0 of the new bank, rcnt<=0, vga_line<=0, synced<=1.
REQ-020 tv_line_start with c3=0 SHALL be ignored.
REQ-021 Read: on f0=1 (no resync that cycle), rcnt increments; at rcnt=LINE_LEN-1 it wraps to 0 and vga_line<=1.
REQ-022 A further wrap with vga_line=1 (late TV line start) SHALL keep vga_line=1 and replay the same bank again.
REQ-023 Resync (REQ-019) SHALL take priority over an f0 increment in the same cycle.
REQ-024 Pipeline: vgaplex, vga_blank, vga_hs, vga_line SHALL all be registered and aligned, 2 clk after the cycle in which rcnt holds the addressed value.
REQ-025 vga_blank=1 when rcnt<ACT_START or rcnt>=ACT_END or synced=0; vgaplex=8'h00 whenever vga_blank=1.
REQ-026 vga_hs=1 when HS_START<=rcnt<HS_END and synced=1; else 0.
REQ-027 vga_plex_sel: 0 on output cycles derived from f0 cycles, 1 on the following cycle; same 2-clk alignment.
REQ-028 Read and write always target different banks; no read/write collision handling is required.
REQ-029 Boundary: TV lines shorter than LINE_LEN leave stale tail data in the bank; no clearing.

Reset
REQ-030 On rst=1: wbank=0, wcnt=0, rcnt=0, synced=0, vga_line=0; all outputs: vgaplex=0, vga_blank=1, vga_hs=0, vga_plex_sel=0 within the 2-clk pipeline depth.
REQ-031 rst mid-line SHALL abort the line; outputs stay blanked until the first tv_line_start after reset release.
REQ-032 Bank RAM contents SHALL not be reset.

Verification
REQ-033 Reset, c3/f0 running, no tv_line_start for 2000 clk -> vga_blank=1, vgaplex=0, vga_hs=0 throughout.
REQ-034 Line N written with vplex_in=addr[7:0], then line start -> on the following line, rcnt=ACT_START gives vgaplex=0x60 two clk later; sequence 0x60..0x9F repeats for vga_line=0 and vga_line=1.
REQ-035 tv_line_start with c3=0 -> no bank swap, rcnt continues, vga_line unchanged.
REQ-036 tv_line_start delayed to 1000 c3 strobes -> wcnt stops at 511, vga_line stays 1 on the third replay, address 0 data unchanged.
REQ-037 tv_line_start, c3 and f0 coincident -> rcnt=0 next cycle (no increment), vga_line=0.
REQ-038 rst asserted at rcnt=200 during active -> vga_blank=1 within 2 clk; resumes only after the next valid tv_line_start.
